// File: rtl/fifo_counted_if.sv
// Producer/consumer bundle for fifo_counted: ready/valid enqueue side, valid/yumi dequeue side,
// plus flush and occupancy status.
interface fifo_counted_if #(
    parameter int unsigned width_p = 8,
    parameter int unsigned depth_p = 128
);
    localparam int unsigned cnt_w = $clog2(depth_p + 1);

    logic               flush_i;
    logic               ready_o;
    logic               valid_i;
    logic [width_p-1:0] data_i;
    logic               valid_o;
    logic [width_p-1:0] data_o;
    logic               yumi_i;
    logic [cnt_w-1:0]   count_o;
    logic               almost_full_o;
    logic               almost_empty_o;
    logic [cnt_w-1:0]   high_water_o;

    modport slave (
        input  flush_i, valid_i, data_i, yumi_i,
        output ready_o, valid_o, data_o, count_o,
               almost_full_o, almost_empty_o, high_water_o
    );

    modport master (
        output flush_i, valid_i, data_i, yumi_i,
        input  ready_o, valid_o, data_o, count_o,
               almost_full_o, almost_empty_o, high_water_o
    );
endinterface

// File: rtl/fifo_counted.sv
// Counted synchronous FIFO for arbitrary depth: occupancy counter drives full/empty so every
// entry is usable; adds almost flags, synchronous flush and a high-water mark.
module fifo_counted #(
    parameter int unsigned width_p        = 8,
    parameter int unsigned depth_p        = 128,
    parameter int unsigned almost_full_p  = 120,
    parameter int unsigned almost_empty_p = 8
) (
    input  logic           clk_i,
    input  logic           reset_i,
    fifo_counted_if.slave  fif
);
    localparam int unsigned ptr_w = ($clog2(depth_p) > 1) ? $clog2(depth_p) : 1;
    localparam int unsigned cnt_w = $clog2(depth_p + 1);

    logic [width_p-1:0] mem_r [depth_p];

    logic [ptr_w-1:0] wr_ptr_r, wr_ptr_n;
    logic [ptr_w-1:0] rd_ptr_r, rd_ptr_n;
    logic [cnt_w-1:0] count_r, count_n;
    logic [cnt_w-1:0] hwm_r, hwm_n;

    logic full_c;
    logic empty_c;
    logic enq_c;
    logic deq_c;

    // Wrap at depth_p-1 explicitly; depth need not be a power of two.
    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(depth_p - 1)) ? '0 : p + ptr_w'(1);
    endfunction

    assign full_c  = (count_r == cnt_w'(depth_p));
    assign empty_c = (count_r == '0);
    assign enq_c   = fif.valid_i & ~full_c;
    assign deq_c   = fif.yumi_i & ~empty_c;

    always_comb begin
        wr_ptr_n = wr_ptr_r;
        rd_ptr_n = rd_ptr_r;
        count_n  = count_r;
        hwm_n    = hwm_r;
        if (fif.flush_i) begin
            wr_ptr_n = '0;
            rd_ptr_n = '0;
            count_n  = '0;
            hwm_n    = '0;
        end else begin
            if (enq_c) wr_ptr_n = ptr_inc(wr_ptr_r);
            if (deq_c) rd_ptr_n = ptr_inc(rd_ptr_r);
            unique case ({enq_c, deq_c})
                2'b10:   count_n = count_r + cnt_w'(1);
                2'b01:   count_n = count_r - cnt_w'(1);
                default: count_n = count_r;
            endcase
            hwm_n = (count_n > hwm_r) ? count_n : hwm_r;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            hwm_r    <= '0;
        end else begin
            wr_ptr_r <= wr_ptr_n;
            rd_ptr_r <= rd_ptr_n;
            count_r  <= count_n;
            hwm_r    <= hwm_n;
        end
    end

    // Storage is never reset or cleared; a flushed-cycle write is suppressed.
    always_ff @(posedge clk_i) begin
        if (enq_c && !fif.flush_i) mem_r[wr_ptr_r] <= fif.data_i;
    end

    // Status depends on registers only, so no input-to-output combinational path.
    assign fif.ready_o        = ~full_c;
    assign fif.valid_o        = ~empty_c;
    assign fif.data_o         = mem_r[rd_ptr_r];
    assign fif.count_o        = count_r;
    assign fif.almost_full_o  = (count_r >= cnt_w'(almost_full_p));
    assign fif.almost_empty_o = (count_r <= cnt_w'(almost_empty_p));
    assign fif.high_water_o   = hwm_r;
endmodule

// File: tb/tb_fifo_counted.sv
// Bench for fifo_counted (depth 5): directed scenarios plus random traffic against a queue model.
module tb_fifo_counted;
    localparam int unsigned width_p = 8;
    localparam int unsigned depth_p = 5;
    localparam int unsigned af_p    = 4;
    localparam int unsigned ae_p    = 1;
    localparam int unsigned cnt_w   = $clog2(depth_p + 1);

    logic clk_i = 1'b0;
    logic reset_i;
    always #5 clk_i = ~clk_i;

    fifo_counted_if #(.width_p(width_p), .depth_p(depth_p)) fif ();

    fifo_counted #(
        .width_p(width_p), .depth_p(depth_p),
        .almost_full_p(af_p), .almost_empty_p(ae_p)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .fif(fif.slave)
    );

    logic [7:0]  mq[$];
    int unsigned mhwm;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Drive one cycle of inputs, let the edge pass, advance the model, sample 1ns later.
    task automatic tick(input logic v, input logic [7:0] d, input logic y, input logic f);
        bit en, de;
        fif.valid_i = v; fif.data_i = d; fif.yumi_i = y; fif.flush_i = f;
        @(posedge clk_i);
        if (reset_i) begin
            mq.delete(); mhwm = 0;
        end else if (f) begin
            mq.delete(); mhwm = 0;
        end else begin
            en = v && (mq.size() < depth_p);
            de = y && (mq.size() > 0);
            if (de) void'(mq.pop_front());
            if (en) mq.push_back(d);
            if (mq.size() > mhwm) mhwm = mq.size();
        end
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        fif.valid_i = 0; fif.data_i = '0; fif.yumi_i = 0; fif.flush_i = 0;
        mq.delete(); mhwm = 0;
        repeat (2) @(posedge clk_i);
        #1;
        n_checks++;
        if ({fif.ready_o, fif.valid_o, fif.almost_empty_o, fif.almost_full_o} !== 4'b1010) begin
            n_fail++;
            $display("FAIL reset_flags: got rdy/vld/ae/af=%b exp 1010",
                     {fif.ready_o, fif.valid_o, fif.almost_empty_o, fif.almost_full_o});
        end
        n_checks++;
        if (fif.count_o !== '0 || fif.high_water_o !== '0) begin
            n_fail++;
            $display("FAIL reset_counts: got count=%0d hwm=%0d exp 0/0", fif.count_o, fif.high_water_o);
        end
        reset_i = 1'b0;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 5; i++) tick(1, 8'(8'h11 + i), 0, 0);
        n_checks++;
        if (fif.ready_o !== 1'b0 || fif.count_o !== cnt_w'(5) || fif.almost_full_o !== 1'b1) begin
            n_fail++;
            $display("FAIL full_state: got rdy=%b cnt=%0d af=%b exp 0/5/1",
                     fif.ready_o, fif.count_o, fif.almost_full_o);
        end
        tick(1, 8'h16, 0, 0);
        n_checks++;
        if (fif.count_o !== cnt_w'(5)) begin
            n_fail++;
            $display("FAIL overflow_drop: got cnt=%0d exp 5", fif.count_o);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (fif.valid_o !== 1'b1 || fif.data_o !== 8'(8'h11 + i)) begin
                n_fail++;
                $display("FAIL drain_%0d: got vld=%b data=%h exp 1/%h", i, fif.valid_o, fif.data_o, 8'(8'h11 + i));
            end
            tick(0, 8'h00, 1, 0);
        end
        n_checks++;
        if (fif.valid_o !== 1'b0 || fif.count_o !== '0) begin
            n_fail++;
            $display("FAIL drain_empty: got vld=%b cnt=%0d exp 0/0", fif.valid_o, fif.count_o);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_d;
        for (int r = 0; r < 2; r++) begin
            int unsigned n;
            n = (r == 0) ? 3 : 4;
            for (int i = 0; i < int'(n); i++) tick(1, 8'(8'h20 + 16 * r + i), 0, 0);
            for (int i = 0; i < int'(n); i++) begin
                exp_d = 8'(8'h20 + 16 * r + i);
                n_checks++;
                if (fif.data_o !== exp_d) begin
                    n_fail++;
                    $display("FAIL wrap_r%0d_%0d: got %h exp %h", r, i, fif.data_o, exp_d);
                end
                tick(0, 8'h00, 1, 0);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        tick(0, 8'h00, 0, 1);
        tick(1, 8'h30, 0, 0);
        tick(1, 8'h31, 0, 0);
        exp_q = '{8'h30, 8'h31};
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (fif.data_o !== exp_q[0]) begin
                n_fail++;
                $display("FAIL b2b_data_%0d: got %h exp %h", i, fif.data_o, exp_q[0]);
            end
            void'(exp_q.pop_front());
            exp_q.push_back(8'(8'h40 + i));
            tick(1, 8'(8'h40 + i), 1, 0);
            n_checks++;
            if (fif.count_o !== cnt_w'(2)) begin
                n_fail++;
                $display("FAIL b2b_count_%0d: got %0d exp 2", i, fif.count_o);
            end
        end
        n_checks++;
        if (fif.high_water_o !== cnt_w'(2)) begin
            n_fail++;
            $display("FAIL b2b_hwm: got %0d exp 2", fif.high_water_o);
        end
    endtask

    task automatic test_full_both();
        logic [7:0] exp_q[$];
        tick(0, 8'h00, 0, 1);
        for (int i = 0; i < 5; i++) tick(1, 8'(8'h50 + i), 0, 0);
        tick(1, 8'h5F, 1, 0);
        n_checks++;
        if (fif.count_o !== cnt_w'(4) || fif.ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL full_both: got cnt=%0d rdy=%b exp 4/1", fif.count_o, fif.ready_o);
        end
        tick(1, 8'h60, 0, 0);
        n_checks++;
        if (fif.count_o !== cnt_w'(5)) begin
            n_fail++;
            $display("FAIL full_refill: got cnt=%0d exp 5", fif.count_o);
        end
        exp_q = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h60};
        foreach (exp_q[i]) begin
            n_checks++;
            if (fif.data_o !== exp_q[i]) begin
                n_fail++;
                $display("FAIL full_order_%0d: got %h exp %h", i, fif.data_o, exp_q[i]);
            end
            tick(0, 8'h00, 1, 0);
        end
    endtask

    task automatic test_flush();
        tick(0, 8'h00, 0, 1);
        for (int i = 0; i < 4; i++) tick(1, 8'(8'h70 + i), 0, 0);
        tick(0, 8'h00, 1, 0);
        n_checks++;
        if (fif.count_o !== cnt_w'(3) || fif.high_water_o !== cnt_w'(4)) begin
            n_fail++;
            $display("FAIL preflush: got cnt=%0d hwm=%0d exp 3/4", fif.count_o, fif.high_water_o);
        end
        tick(1, 8'h77, 0, 1);
        n_checks++;
        if (fif.count_o !== '0 || fif.high_water_o !== '0 || fif.valid_o !== 1'b0 ||
            fif.almost_empty_o !== 1'b1 || fif.almost_full_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush: got cnt=%0d hwm=%0d vld=%b ae=%b af=%b exp 0/0/0/1/0",
                     fif.count_o, fif.high_water_o, fif.valid_o, fif.almost_empty_o, fif.almost_full_o);
        end
        tick(0, 8'h00, 1, 0);
        n_checks++;
        if (fif.count_o !== '0) begin
            n_fail++;
            $display("FAIL empty_yumi: got cnt=%0d exp 0", fif.count_o);
        end
        tick(1, 8'h88, 0, 0);
        n_checks++;
        if (fif.valid_o !== 1'b1 || fif.data_o !== 8'h88 || fif.almost_empty_o !== 1'b1) begin
            n_fail++;
            $display("FAIL post_flush_enq: got vld=%b data=%h ae=%b exp 1/88/1",
                     fif.valid_o, fif.data_o, fif.almost_empty_o);
        end
        tick(0, 8'h00, 1, 0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) tick(1, 8'(8'h90 + i), 0, 0);
        #2;
        reset_i = 1'b1;
        #1;
        n_checks++;
        if (fif.count_o !== '0 || fif.valid_o !== 1'b0 || fif.ready_o !== 1'b1 ||
            fif.high_water_o !== '0 || fif.almost_empty_o !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: got cnt=%0d vld=%b rdy=%b hwm=%0d ae=%b exp 0/0/1/0/1",
                     fif.count_o, fif.valid_o, fif.ready_o, fif.high_water_o, fif.almost_empty_o);
        end
        tick(0, 8'h00, 0, 0);
        reset_i = 1'b0;
        tick(1, 8'hA5, 0, 0);
        n_checks++;
        if (fif.valid_o !== 1'b1 || fif.data_o !== 8'hA5 || fif.count_o !== cnt_w'(1)) begin
            n_fail++;
            $display("FAIL reset_reenq: got vld=%b data=%h cnt=%0d exp 1/a5/1",
                     fif.valid_o, fif.data_o, fif.count_o);
        end
        tick(0, 8'h00, 1, 0);
    endtask

    task automatic test_random();
        int unsigned sz;
        for (int i = 0; i < 400; i++) begin
            tick(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 99) < 45),
                 1'($urandom_range(0, 99) < 3));
            sz = mq.size();
            n_checks++;
            if (fif.count_o !== cnt_w'(sz) || fif.valid_o !== (sz != 0) ||
                fif.ready_o !== (sz != depth_p) || fif.almost_full_o !== (sz >= af_p) ||
                fif.almost_empty_o !== (sz <= ae_p) || fif.high_water_o !== cnt_w'(mhwm)) begin
                n_fail++;
                $display("FAIL rand_status_%0d: got cnt=%0d vld=%b rdy=%b af=%b ae=%b hwm=%0d exp cnt=%0d hwm=%0d",
                         i, fif.count_o, fif.valid_o, fif.ready_o, fif.almost_full_o,
                         fif.almost_empty_o, fif.high_water_o, sz, mhwm);
            end
            if (sz != 0) begin
                n_checks++;
                if (fif.data_o !== mq[0]) begin
                    n_fail++;
                    $display("FAIL rand_data_%0d: got %h exp %h", i, fif.data_o, mq[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_back_to_back();
        test_full_both();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
